// File: rtl/vga_pkg.sv
// Package: shared timing types, 640x480@60 default constants and width helpers
// for the VGA pixel pipeline.
//   vga_timing_t   : {active, fp, sync, bp} description of one axis
//   addr_w()       : counter/address width for a count of n values, min 1
//   timing_total() : active + fp + sync + bp
package vga_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } vga_timing_t;

  // 640x480@60 defaults
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam vga_timing_t VGA_640X480_H = '{active: H_ACTIVE_DEF, fp: H_FP_DEF,
                                            sync: H_SYNC_DEF, bp: H_BP_DEF};
  localparam vga_timing_t VGA_640X480_V = '{active: V_ACTIVE_DEF, fp: V_FP_DEF,
                                            sync: V_SYNC_DEF, bp: V_BP_DEF};

  localparam int RGB_W      = 24;
  localparam int MAX_RD_LAT = 4;

  // Width needed to hold 0..n-1; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int timing_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-advanced shift register used to align control bits with the
// frame-buffer read latency.
//   clk_i : clock
//   rst_i : synchronous active-high reset, fills every stage with RST_VAL
//   en_i  : shift enable
//   d_i   : input word
//   q_o   : word entered DEPTH enabled cycles ago (DEPTH 0 = straight wire)
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_s;
    assign unused_s = clk_i ^ rst_i ^ en_i;
    assign q_o      = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift chain; reset wins over enable so in-flight words are dropped.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_pipe_ctrl.sv
// Parametrised VGA timing generator and pixel output stage.
// Raster counters drive a registered frame-buffer request (stage 0); sync,
// request and frame-start bits travel through an RD_LAT-deep delay line so
// they meet the returned pixel data in the output register.
//   pclk, reset, pix_en           : clock, sync active-high reset, advance enable
//   req, h_addr, v_addr           : frame-buffer read request and pixel address
//   vga_data                      : {R,G,B} returned RD_LAT pix_en cycles after req
//   hsync, vsync, valid           : output-aligned sync and active-video flags
//   frame_start                   : pulse with pixel (0,0) on the RGB outputs
//   vga_r, vga_g, vga_b           : registered colour outputs
module vga_pipe_ctrl
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          H_FP        = H_FP_DEF,
  parameter int          H_SYNC      = H_SYNC_DEF,
  parameter int          H_BP        = H_BP_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          V_FP        = V_FP_DEF,
  parameter int          V_SYNC      = V_SYNC_DEF,
  parameter int          V_BP        = V_BP_DEF,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int          RD_LAT      = 1,
  parameter logic [23:0] BLANK_COLOR = 24'h000000
) (
  input  logic                          pclk,
  input  logic                          reset,
  input  logic                          pix_en,
  output logic                          req,
  output logic [addr_w(H_ACTIVE)-1:0]   h_addr,
  output logic [addr_w(V_ACTIVE)-1:0]   v_addr,
  input  logic [23:0]                   vga_data,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          valid,
  output logic                          frame_start,
  output logic [7:0]                    vga_r,
  output logic [7:0]                    vga_g,
  output logic [7:0]                    vga_b
);

  localparam vga_timing_t H_TIM = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_TIM = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int H_TOTAL = timing_total(H_TIM);
  localparam int V_TOTAL = timing_total(V_TIM);
  localparam int HCW     = addr_w(H_TOTAL);
  localparam int VCW     = addr_w(V_TOTAL);
  localparam int HAW     = addr_w(H_ACTIVE);
  localparam int VAW     = addr_w(V_ACTIVE);

  localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SS   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SE   = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SS   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SE   = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Delay-line word layout: {hs, vs, req, fs}; idle value is inactive sync.
  localparam logic [3:0] DLY_IDLE = {~HS_POL, ~VS_POL, 1'b0, 1'b0};

  if (RD_LAT < 0 || RD_LAT > MAX_RD_LAT || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_cfg
    $error("vga_pipe_ctrl: RD_LAT must be 0..4 and all porch/sync widths non-zero");
  end

  logic [HCW-1:0] h_cnt_q, h_cnt_d;
  logic [VCW-1:0] v_cnt_q, v_cnt_d;
  logic           req_q, req_d;
  logic [HAW-1:0] h_addr_q, h_addr_d;
  logic [VAW-1:0] v_addr_q, v_addr_d;
  logic           hs0_q, hs0_d;
  logic           vs0_q, vs0_d;
  logic           fs0_q, fs0_d;
  logic [3:0]     dly_s;
  logic           hsync_q, vsync_q, valid_q, fs_q;
  logic [23:0]    rgb_q, rgb_d;

  // Raster counter next state: h wraps to 0 and carries into v on the same edge.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // Stage-0 decode of the current raster position.
  always_comb begin
    req_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    h_addr_d = req_d ? h_cnt_q[HAW-1:0] : '0;
    v_addr_d = req_d ? v_cnt_q[VAW-1:0] : '0;
    hs0_d    = ((h_cnt_q >= H_SS) && (h_cnt_q <= H_SE)) ? HS_POL : ~HS_POL;
    vs0_d    = ((v_cnt_q >= V_SS) && (v_cnt_q <= V_SE)) ? VS_POL : ~VS_POL;
    fs0_d    = req_d && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Counters and stage-0 registers; a stall freezes the request address too.
  always_ff @(posedge pclk) begin
    if (reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      req_q    <= 1'b0;
      h_addr_q <= '0;
      v_addr_q <= '0;
      hs0_q    <= ~HS_POL;
      vs0_q    <= ~VS_POL;
      fs0_q    <= 1'b0;
    end else if (pix_en) begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      req_q    <= req_d;
      h_addr_q <= h_addr_d;
      v_addr_q <= v_addr_d;
      hs0_q    <= hs0_d;
      vs0_q    <= vs0_d;
      fs0_q    <= fs0_d;
    end
  end

  vga_delay_line #(
    .WIDTH   (4),
    .DEPTH   (RD_LAT),
    .RST_VAL (DLY_IDLE)
  ) u_dly (
    .clk_i (pclk),
    .rst_i (reset),
    .en_i  (pix_en),
    .d_i   ({hs0_q, vs0_q, req_q, fs0_q}),
    .q_o   (dly_s)
  );

  // Colour select: frame-buffer data only for delayed-active pixels.
  always_comb begin
    if (dly_s[1]) begin
      rgb_d = vga_data;
    end else begin
      rgb_d = BLANK_COLOR;
    end
  end

  // Output register, one stage after the delay line so sync and video stay aligned.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= BLANK_COLOR;
    end else if (pix_en) begin
      hsync_q <= dly_s[3];
      vsync_q <= dly_s[2];
      valid_q <= dly_s[1];
      fs_q    <= dly_s[0];
      rgb_q   <= rgb_d;
    end
  end

  assign req         = req_q;
  assign h_addr      = h_addr_q;
  assign v_addr      = v_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign frame_start = fs_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
